// File: rtl/sample_window_loader_if.sv
// sample_window_loader_if: streaming sample input plus the parallel window
// output bundle of sample_window_loader.
//   in_data/in_valid/in_ready : sample handshake (ready is combinational)
//   mode/flush                : framing mode select and partial-window abort
//   a..h                      : window lanes, a = oldest, h = newest
//   win_valid                 : one-cycle strobe on new lane contents
//   win_count                 : windows emitted, wraps modulo 2^CNT_W
//   fill_level                : samples currently buffered (0..8)
// master = producer/consumer side (testbench), slave = the loader.
interface sample_window_loader_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic             flush;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic             win_valid;
  logic [CNT_W-1:0] win_count;
  logic [3:0]       fill_level;

  modport master (
    output in_data, in_valid, mode, flush,
    input  in_ready, a, b, c, d, e, f, g, h, win_valid, win_count, fill_level
  );

  modport slave (
    input  in_data, in_valid, mode, flush,
    output in_ready, a, b, c, d, e, f, g, h, win_valid, win_count, fill_level
  );
endinterface

// File: rtl/sample_window_loader.sv
// sample_window_loader: packs a serial sample stream into 8-sample windows
// for the 8-input adder tree. Block mode emits non-overlapping windows;
// sliding mode emits a window on every accept once 8 samples are held.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  sample_window_loader_if.slave (handshake in, lanes/status out)
module sample_window_loader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  sample_window_loader_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

  state_t                 state_q, state_d;
  // Index 0 is the oldest sample, index 7 the newest.
  logic [7:0][WIDTH-1:0]  buf_q, buf_d;
  logic [7:0][WIDTH-1:0]  shifted;
  logic [7:0][WIDTH-1:0]  lane_q;
  logic [3:0]             fill_q, fill_d;
  logic                   mode_q, mode_d;
  logic                   accept;
  logic                   emit;
  logic                   wv_q;
  logic [CNT_W-1:0]       cnt_q;

  assign bus.in_ready = !bus.flush;
  assign accept       = bus.in_valid && !bus.flush;
  // Buffer after accepting the current sample; also the emitted window.
  assign shifted      = {bus.in_data, buf_q[7:1]};

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    mode_d  = mode_q;
    buf_d   = buf_q;
    emit    = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
      fill_d  = 4'd0;
      buf_d   = '0;
    end else if (accept) begin
      buf_d = shifted;
      case (state_q)
        EMPTY: begin
          state_d = FILL;
          fill_d  = 4'd1;
          mode_d  = bus.mode;
        end
        FILL: begin
          if (fill_q == 4'd7) begin
            emit = 1'b1;
            // Block mode leaves stale data in buf_q; eight fresh accepts
            // displace all of it before the next emit.
            state_d = mode_q ? FULL : EMPTY;
            fill_d  = mode_q ? 4'd8 : 4'd0;
          end else begin
            fill_d = fill_q + 4'd1;
          end
        end
        FULL: emit = 1'b1;
        default: begin
          state_d = EMPTY;
          fill_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      fill_q  <= 4'd0;
      mode_q  <= 1'b0;
      lane_q  <= '0;
      wv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      mode_q  <= mode_d;
      wv_q    <= emit;
      if (emit) begin
        lane_q <= shifted;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.a          = lane_q[0];
  assign bus.b          = lane_q[1];
  assign bus.c          = lane_q[2];
  assign bus.d          = lane_q[3];
  assign bus.e          = lane_q[4];
  assign bus.f          = lane_q[5];
  assign bus.g          = lane_q[6];
  assign bus.h          = lane_q[7];
  assign bus.win_valid  = wv_q;
  assign bus.win_count  = cnt_q;
  assign bus.fill_level = fill_q;

endmodule

// File: tb/tb_sample_window_loader.sv
// Directed, table-driven bench for sample_window_loader, plus hand-written
// sequences for asynchronous reset mid-fill and the window counter wrap.
module tb_sample_window_loader;

  typedef logic [7:0][7:0] lanes_t;  // index 0 = lane a

  typedef struct {
    bit          rst;
    bit          v;
    logic [7:0]  d;
    bit          m;
    bit          f;
    bit          ewv;
    logic [3:0]  efill;
    logic [15:0] ecnt;
    lanes_t      el;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sample_window_loader_if #(.WIDTH(8), .CNT_W(16)) bus ();
  sample_window_loader_if #(.WIDTH(8), .CNT_W(4))  wif ();

  sample_window_loader #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  sample_window_loader #(.WIDTH(8), .CNT_W(4)) u_wrap (
    .clk(clk), .rst(rst), .bus(wif.slave)
  );

  lanes_t act;
  assign act = {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic lanes_t seq(int s);
    lanes_t l;
    for (int i = 0; i < 8; i++) l[i] = 8'(s + i);
    return l;
  endfunction

  task automatic add(bit r, bit v, int d, bit m, bit f, bit ewv, int efill,
                     int ecnt, lanes_t el);
    vec_t x;
    x.rst = r; x.v = v; x.d = 8'(d); x.m = m; x.f = f;
    x.ewv = ewv; x.efill = 4'(efill); x.ecnt = 16'(ecnt); x.el = el;
    tbl.push_back(x);
  endtask

  task automatic add_rst();
    add(1, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic check(string name, bit ok, string got, string want);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  initial begin
    logic       rdy;
    logic [10:0] sum;
    bit         ok;

    bus.in_valid = 0; bus.in_data = 0; bus.mode = 0; bus.flush = 0;
    wif.in_valid = 0; wif.in_data = 0; wif.mode = 0; wif.flush = 0;

    // Block mode 1..8 back-to-back.
    add_rst();
    for (int k = 1; k <= 8; k++)
      add(0, 1, k, 0, 0, k == 8, (k == 8) ? 0 : k, (k == 8) ? 1 : 0,
          (k == 8) ? seq(1) : '0);
    add(0, 0, 0, 0, 0, 0, 0, 1, seq(1));

    // Block mode 1..16 with in_valid toggling.
    add_rst();
    for (int k = 1; k <= 16; k++) begin
      add(0, 1, k, 0, 0, (k == 8) || (k == 16), k % 8,
          (k < 8) ? 0 : ((k < 16) ? 1 : 2),
          (k < 8) ? '0 : ((k < 16) ? seq(1) : seq(9)));
      add(0, 0, 0, 0, 0, 0, k % 8,
          (k < 8) ? 0 : ((k < 16) ? 1 : 2),
          (k < 8) ? '0 : ((k < 16) ? seq(1) : seq(9)));
    end

    // Sliding mode 1..10 back-to-back.
    add_rst();
    for (int k = 1; k <= 10; k++)
      add(0, 1, k, 1, 0, k >= 8, (k >= 8) ? 8 : k, (k >= 8) ? k - 7 : 0,
          (k >= 8) ? seq(k - 7) : '0);
    add(0, 0, 0, 1, 0, 0, 8, 3, seq(3));

    // Flush from FULL, partial block fill, flush with in_valid.
    add(0, 1, 99, 0, 1, 0, 0, 3, seq(3));
    for (int k = 0; k < 5; k++) add(0, 1, 20 + k, 0, 0, 0, k + 1, 3, seq(3));
    add(0, 1, 25, 0, 1, 0, 0, 3, seq(3));
    // Sliding after flush, then mode change ignored while FULL.
    for (int k = 0; k < 8; k++)
      add(0, 1, 100 + k, 1, 0, k == 7, (k == 7) ? 8 : k + 1, (k == 7) ? 4 : 3,
          (k == 7) ? seq(100) : seq(3));
    add(0, 1, 108, 0, 0, 1, 8, 5, seq(101));
    // Flush coinciding with what would be the 8th accept.
    add(0, 0, 0, 0, 1, 0, 0, 5, seq(101));
    for (int k = 0; k < 7; k++) add(0, 1, 30 + k, 0, 0, 0, k + 1, 5, seq(101));
    add(0, 1, 37, 0, 1, 0, 0, 5, seq(101));
    add(0, 0, 0, 0, 0, 0, 0, 5, seq(101));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst          = tbl[i].rst;
      bus.in_valid = tbl[i].v;
      bus.in_data  = tbl[i].d;
      bus.mode     = tbl[i].m;
      bus.flush    = tbl[i].f;
      #1 rdy = bus.in_ready;
      @(posedge clk);
      #1;
      ok = (bus.win_valid == tbl[i].ewv) && (bus.fill_level == tbl[i].efill) &&
           (bus.win_count == tbl[i].ecnt) && (act == tbl[i].el) &&
           (rdy == !tbl[i].f);
      check($sformatf("vec%0d", i), ok,
            $sformatf("wv=%0b fill=%0d cnt=%0d lanes=%h rdy=%0b",
                      bus.win_valid, bus.fill_level, bus.win_count, act, rdy),
            $sformatf("wv=%0b fill=%0d cnt=%0d lanes=%h rdy=%0b",
                      tbl[i].ewv, tbl[i].efill, tbl[i].ecnt, tbl[i].el, !tbl[i].f));
    end

    // Asynchronous reset mid-fill.
    @(negedge clk);
    rst = 0; bus.flush = 0; bus.mode = 0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1; bus.in_data = 8'(40 + k);
      @(negedge clk);
    end
    bus.in_valid = 0;
    check("fill_before_rst", bus.fill_level == 4'd3,
          $sformatf("%0d", bus.fill_level), "3");
    @(posedge clk);
    #3 rst = 1;
    #1;
    ok = (bus.win_valid == 0) && (bus.fill_level == 0) &&
         (bus.win_count == 0) && (act == '0);
    check("async_rst", ok,
          $sformatf("wv=%0b fill=%0d cnt=%0d lanes=%h", bus.win_valid,
                    bus.fill_level, bus.win_count, act),
          "all zero");
    #1 rst = 0;

    // Eight 255s: extreme lane values, tree sum 2040.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.in_valid = 1; bus.in_data = 8'hff;
    end
    @(posedge clk);
    #1;
    sum = 0;
    for (int i = 0; i < 8; i++) sum += 11'(act[i]);
    ok = (bus.win_valid == 1) && (bus.win_count == 1) && (act == {8{8'hff}});
    check("max_window", ok,
          $sformatf("wv=%0b cnt=%0d lanes=%h", bus.win_valid, bus.win_count, act),
          "wv=1 cnt=1 lanes=ffffffffffffffff");
    check("max_sum", sum == 11'd2040, $sformatf("%0d", sum), "2040");
    @(negedge clk);
    bus.in_valid = 0;

    // Counter wrap on the CNT_W=4 instance: 17 block windows.
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int w = 1; w <= 17; w++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        wif.in_valid = 1; wif.in_data = 8'(w);
      end
      @(posedge clk);
      #1;
      if (w >= 15) begin
        ok = (wif.win_valid == 1) && (wif.win_count == 4'(w % 16));
        check($sformatf("wrap_w%0d", w), ok,
              $sformatf("wv=%0b cnt=%0d", wif.win_valid, wif.win_count),
              $sformatf("wv=1 cnt=%0d", w % 16));
      end
    end
    @(negedge clk);
    wif.in_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sample_window_loader.md
# sample_window_loader

Upstream feeder for the 8-input adder tree. It accepts a serial stream of 8-bit samples over a valid/ready handshake, packs them into 8-sample windows, and presents each window on eight parallel registered lanes `a`..`h`, held stable between windows, with a one-cycle `win_valid` strobe. Two framing modes are supported: non-overlapping block windows and a sliding window that advances by one sample.

## Interface
- `WIDTH`, 8: sample and lane width. The downstream tree sums to `WIDTH+3` bits, so 8×255 = 2040 fits in 11 bits.
- `CNT_W`, 16: width of the window counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  WIDTH  sample.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  block can accept a sample. It is combinational and equals `!flush`.
- `mode`  in  1  framing mode: 0 = block windows, 1 = sliding window.
- `flush`  in  1  synchronous abort of the partial window.
- `a`, `b`, `c`, `d`, `e`, `f`, `g`, `h`  out  WIDTH each  window lanes. `a` holds the oldest sample and `h` the newest.
- `win_valid`  out  1  one-cycle strobe marking new lane contents.
- `win_count`  out  CNT_W  number of windows emitted, modulo 2^CNT_W.
- `fill_level`  out  4  samples currently buffered (0..8).

## Operation
- A sample is accepted on a rising edge where `in_valid && in_ready`.
- Internal 8-entry shift buffer:
  - Each accepted sample enters at the newest position.
  - Older entries shift toward the oldest position.
- Mode latching:
  - `mode` is latched into `mode_q` on the first accept from EMPTY.
  - Changes to `mode` at any other time are ignored until the block next returns to EMPTY.
- State machine:
  - EMPTY (fill 0):
    - accept → FILL, fill = 1.
  - FILL (fill 1..7):
    - accept with fill < 7 → fill + 1.
    - accept with fill = 7 → emit window, then:
      - if `mode_q` = 0: go to EMPTY, fill = 0;
      - if `mode_q` = 1: go to FULL, fill = 8.
  - FULL (sliding only, fill 8):
    - every accept drops the oldest sample and emits a window of the last 8 samples.
    - the state stays FULL.
  - `flush` = 1 in any state:
    - next state EMPTY, fill = 0, buffer cleared to 0.
    - the sample offered in that cycle is not accepted, because `in_ready` = 0.
- Emitting a window:
  - `a`..`h` load the completed 8 samples, oldest to newest.
  - `win_valid` = 1 for exactly one cycle.
  - `win_count` increments and wraps from 2^CNT_W−1 to 0.
- Lanes `a`..`h` change only on an emit. Flush, idle cycles and partial fills leave them untouched.
- `in_valid` gaps of any length are allowed. Nothing advances without an accept.

## Timing
- Reset values: `a`..`h` = 0, `win_valid` = 0, `win_count` = 0, `fill_level` = 0, state EMPTY, buffer = 0, `mode_q` = 0.
- Reset asserted mid-fill discards the partial window immediately (asynchronous). The first accept after release starts a new window.
- Latency: if the 8th sample is accepted on edge k, then after edge k:
  - `a`..`h` hold the new window;
  - `win_valid` = 1 and `win_count` is incremented;
  - `win_valid` drops after edge k+1 unless another emit happens on edge k+1.
- Sliding mode with `in_valid` held high gives `win_valid` high on consecutive cycles, one window per accept, with no bubble.
- `flush` and `in_valid` in the same cycle: flush wins and the sample is dropped.
- `flush` on the same cycle as what would be the 8th accept: no emit; lanes and `win_count` keep their previous values.
- `in_ready` has no dependence on state. The block never stalls except during flush.
- `fill_level` is registered and updates on the same edge as the accept.

## Test plan
- Block mode: reset, then feed 1..8 on consecutive cycles.
  - Expect exactly one `win_valid` pulse, on the cycle after the 8th accept.
  - `a`..`h` = 1..8, `win_count` = 1, `fill_level` returns to 0.
  - The downstream tree produces `y` = 36 after its latency.
- Block mode with gaps: feed 1..16 with `in_valid` toggling 1/0.
  - Expect two pulses: the first with `a`..`h` = 1..8, the second with `a`..`h` = 9..16.
  - Lanes hold 1..8 between the two pulses, and `win_count` = 2.
- Sliding mode: `mode` = 1, feed 1..10 back-to-back.
  - Expect pulses after samples 8, 9 and 10 on consecutive cycles.
  - Windows are 1..8 (sum 36), 2..9 (sum 44) and 3..10 (sum 52), ending with `fill_level` = 8.
- Flush and mode change: in block mode feed 5 samples, then assert `flush` together with `in_valid`.
  - Expect no pulse, `fill_level` = 0, and lanes unchanged.
  - Toggle `mode` to 1 after the flush, then feed 100..107: a single window `a`..`h` = 100..107 and the block enters FULL.
- Reset mid-fill and extreme values:
  - Feed 3 samples, then pulse `rst` asynchronously between edges. Expect all outputs 0 immediately.
  - Then feed eight 255s: expect `a`..`h` = 255 and a tree sum of 2040.
- Counter wrap: with `CNT_W` = 4, emit 17 block windows. `win_count` reads 15, 0, 1 over the last three windows.
